// File: rtl/pc_stall_ctrl_pkg.sv
// Shared control definitions for the pipeline stall scheduler: MD FSM states,
// register-number width, default MD latencies and the operand match helper.
package cpu_ctrl_pkg;

  localparam int REG_W        = 5;
  localparam int MULT_LAT_DEF = 5;
  localparam int DIV_LAT_DEF  = 32;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mdState_t;

  // Register $0 never carries a dependency, so it is excluded from every match.
  function automatic logic regMatch(input logic useReg,
                                    input logic [REG_W-1:0] srcReg,
                                    input logic [REG_W-1:0] dstReg);
    return useReg && (srcReg != '0) && (srcReg == dstReg);
  endfunction

endpackage

// File: rtl/pc_stall_ctrl_if.sv
// Stage-signal bundle between the decode/EX/MEM pipeline and the stall scheduler.
// master = pipeline side, slave = pc_stall_ctrl.
interface pc_stall_ctrl_if;
  import cpu_ctrl_pkg::*;

  logic [REG_W-1:0] RsD;
  logic [REG_W-1:0] RtD;
  logic             UseRsD;
  logic             UseRtD;
  logic             IsJBrD;
  logic             MdStartD;
  logic             MdDivD;
  logic             MdUseD;
  logic [REG_W-1:0] WriteRegE;
  logic             RegWriteE;
  logic             MemReadE;
  logic [REG_W-1:0] WriteRegM;
  logic             MemReadM;
  logic             MemWaitM;
  logic             PCEn;
  logic             IFIDEn;
  logic             IDEXEn;
  logic             IDEXFlush;
  logic             MdBusy;
  logic             MdDone;

  modport master (
    output RsD, RtD, UseRsD, UseRtD, IsJBrD, MdStartD, MdDivD, MdUseD,
           WriteRegE, RegWriteE, MemReadE, WriteRegM, MemReadM, MemWaitM,
    input  PCEn, IFIDEn, IDEXEn, IDEXFlush, MdBusy, MdDone
  );

  modport slave (
    input  RsD, RtD, UseRsD, UseRtD, IsJBrD, MdStartD, MdDivD, MdUseD,
           WriteRegE, RegWriteE, MemReadE, WriteRegM, MemReadM, MemWaitM,
    output PCEn, IFIDEn, IDEXEn, IDEXFlush, MdBusy, MdDone
  );

endinterface

// File: rtl/pc_stall_ctrl_md_busy_fsm.sv
// Multiply/divide occupancy tracker: a down-counter loaded on an accepted start,
// with a registered busy flag and a one-cycle done pulse after the last busy cycle.
module md_busy_fsm
  import cpu_ctrl_pkg::*;
#(
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int DIV_LAT  = DIV_LAT_DEF,
  parameter int CNT_W    = 6
) (
  input  logic clk,
  input  logic rst_n,
  input  logic mdStart,
  input  logic mdDiv,
  output logic mdBusy,
  output logic mdDone
);

  localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_LAT);
  localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_LAT);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(1);

  mdState_t         state;
  logic [CNT_W-1:0] cnt;

  // The counter keeps running through memory freezes; the MD unit is not
  // part of the frozen front end. mdStart is only qualified by the caller.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      mdBusy <= 1'b0;
      mdDone <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          mdDone <= 1'b0;
          if (mdStart) begin
            cnt    <= mdDiv ? DIV_CNT : MULT_CNT;
            state  <= BUSY;
            mdBusy <= 1'b1;
          end
        end
        BUSY: begin
          if (cnt == LAST_CNT) begin
            cnt    <= '0;
            state  <= IDLE;
            mdBusy <= 1'b0;
            mdDone <= 1'b1;
          end else begin
            cnt    <= cnt - LAST_CNT;
            mdDone <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          cnt    <= '0;
          mdBusy <= 1'b0;
          mdDone <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/pc_stall_ctrl.sv
// Hazard and stall scheduler for the 5-stage pipeline: PC / IF-ID / ID-EX control.
// Optional PC_STALL_PERF_EN adds saturating StallCnt / FreezeCnt counters.
module pc_stall_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int DIV_LAT  = DIV_LAT_DEF,
  parameter int CNT_W    = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  pc_stall_ctrl_if.slave    bus
`ifdef PC_STALL_PERF_EN
  ,
  output logic [31:0]       StallCnt,
  output logic [31:0]       FreezeCnt
`endif
);

  logic rsMatchE, rtMatchE, rsMatchM, rtMatchM;
  logic luse, brh, mdh, stall;
  logic mdStartAcc;
  logic mdBusy, mdDone;

  assign rsMatchE = regMatch(bus.UseRsD, bus.RsD, bus.WriteRegE);
  assign rtMatchE = regMatch(bus.UseRtD, bus.RtD, bus.WriteRegE);
  assign rsMatchM = regMatch(bus.UseRsD, bus.RsD, bus.WriteRegM);
  assign rtMatchM = regMatch(bus.UseRtD, bus.RtD, bus.WriteRegM);

  // Branches resolve in ID, so they also wait on ALU results still in EX and
  // on loads that have only reached MEM.
  assign luse  = bus.MemReadE && (rsMatchE || rtMatchE);
  assign brh   = bus.IsJBrD &&
                 ((bus.RegWriteE && (rsMatchE || rtMatchE)) ||
                  (bus.MemReadM  && (rsMatchM || rtMatchM)));
  assign mdh   = mdBusy && (bus.MdUseD || bus.MdStartD);
  assign stall = luse || brh || mdh;

  assign mdStartAcc = bus.MdStartD && !stall && !bus.MemWaitM;

  md_busy_fsm #(
    .MULT_LAT (MULT_LAT),
    .DIV_LAT  (DIV_LAT),
    .CNT_W    (CNT_W)
  ) uMdBusyFsm (
    .clk     (clk),
    .rst_n   (rst_n),
    .mdStart (mdStartAcc),
    .mdDiv   (bus.MdDivD),
    .mdBusy  (mdBusy),
    .mdDone  (mdDone)
  );

  assign bus.MdBusy = mdBusy;
  assign bus.MdDone = mdDone;

  // A memory wait freezes everything, including ID/EX, so no bubble is needed.
  always_comb begin
    bus.PCEn      = 1'b1;
    bus.IFIDEn    = 1'b1;
    bus.IDEXEn    = 1'b1;
    bus.IDEXFlush = 1'b0;
    if (bus.MemWaitM) begin
      bus.PCEn   = 1'b0;
      bus.IFIDEn = 1'b0;
      bus.IDEXEn = 1'b0;
    end else if (stall) begin
      bus.PCEn      = 1'b0;
      bus.IFIDEn    = 1'b0;
      bus.IDEXFlush = 1'b1;
    end
  end

`ifdef PC_STALL_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      StallCnt  <= '0;
      FreezeCnt <= '0;
    end else begin
      if (stall && !bus.MemWaitM && (StallCnt != 32'hFFFF_FFFF))
        StallCnt <= StallCnt + 32'd1;
      if (bus.MemWaitM && (FreezeCnt != 32'hFFFF_FFFF))
        FreezeCnt <= FreezeCnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pc_stall_ctrl.sv
// Scoreboard bench for pc_stall_ctrl: directed hazard sequences plus random traffic,
// checked against a timestamp model of the MD unit and the hazard rules.
module tb_pc_stall_ctrl;

  localparam int MULT_L = 5;
  localparam int DIV_L  = 32;

  typedef struct {
    bit       rst;
    bit [4:0] rs;
    bit [4:0] rt;
    bit       useRs;
    bit       useRt;
    bit       isJBr;
    bit       mdStart;
    bit       mdDiv;
    bit       mdUse;
    bit [4:0] wrE;
    bit       regWrE;
    bit       memRdE;
    bit [4:0] wrM;
    bit       memRdM;
    bit       memWait;
  } stim_t;

  typedef struct {
    bit pcEn;
    bit ifidEn;
    bit idexEn;
    bit flush;
    bit busy;
    bit done;
    int cyc;
  } exp_t;

  logic clk;
  logic rst_n;
  pc_stall_ctrl_if bus();

`ifdef PC_STALL_PERF_EN
  logic [31:0] StallCnt;
  logic [31:0] FreezeCnt;
  longint expStallCnt = 0;
  longint expFreezeCnt = 0;
`endif

  pc_stall_ctrl #(
    .MULT_LAT (MULT_L),
    .DIV_LAT  (DIV_L),
    .CNT_W    (6)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus)
`ifdef PC_STALL_PERF_EN
    ,
    .StallCnt  (StallCnt),
    .FreezeCnt (FreezeCnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t expQ[$];
  int   checks = 0;
  int   errors = 0;

  // MD occupancy as absolute cycle windows rather than a counter.
  int cyc     = 0;
  int busyFrom = 0;
  int busyTo   = -1;
  int doneAt   = -1;

  function automatic bit refMatch(bit useReg, bit [4:0] src, bit [4:0] dst);
    return useReg && (src != 0) && (src == dst);
  endfunction

  function automatic stim_t quiet();
    stim_t s;
    s = '{default: '0};
    s.rst = 1'b1;
    return s;
  endfunction

  task automatic checkBit(input string name, input int c, input logic act, input bit req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s cycle %0d: got %b, expected %b", name, c, act, req);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    checkBit("PCEn",      e.cyc, bus.PCEn,      e.pcEn);
    checkBit("IFIDEn",    e.cyc, bus.IFIDEn,    e.ifidEn);
    checkBit("IDEXEn",    e.cyc, bus.IDEXEn,    e.idexEn);
    checkBit("IDEXFlush", e.cyc, bus.IDEXFlush, e.flush);
    checkBit("MdBusy",    e.cyc, bus.MdBusy,    e.busy);
    checkBit("MdDone",    e.cyc, bus.MdDone,    e.done);
  endtask

  // One cycle of stimulus: drive just after the edge, predict, then advance the model.
  task automatic applyStimulus(input stim_t s);
    exp_t e;
    bit mE, mM, luse, brh, mdh, stall;
    int lat;
    @(posedge clk);
    #1;
    rst_n         = s.rst;
    bus.RsD       = s.rs;
    bus.RtD       = s.rt;
    bus.UseRsD    = s.useRs;
    bus.UseRtD    = s.useRt;
    bus.IsJBrD    = s.isJBr;
    bus.MdStartD  = s.mdStart;
    bus.MdDivD    = s.mdDiv;
    bus.MdUseD    = s.mdUse;
    bus.WriteRegE = s.wrE;
    bus.RegWriteE = s.regWrE;
    bus.MemReadE  = s.memRdE;
    bus.WriteRegM = s.wrM;
    bus.MemReadM  = s.memRdM;
    bus.MemWaitM  = s.memWait;

    e.cyc  = cyc;
    e.busy = s.rst && (cyc >= busyFrom) && (cyc <= busyTo);
    e.done = s.rst && (cyc == doneAt);
    mE    = refMatch(s.useRs, s.rs, s.wrE) || refMatch(s.useRt, s.rt, s.wrE);
    mM    = refMatch(s.useRs, s.rs, s.wrM) || refMatch(s.useRt, s.rt, s.wrM);
    luse  = s.memRdE && mE;
    brh   = s.isJBr && ((s.regWrE && mE) || (s.memRdM && mM));
    mdh   = e.busy && (s.mdUse || s.mdStart);
    stall = luse || brh || mdh;
    if (s.memWait) begin
      e.pcEn = 0; e.ifidEn = 0; e.idexEn = 0; e.flush = 0;
    end else if (stall) begin
      e.pcEn = 0; e.ifidEn = 0; e.idexEn = 1; e.flush = 1;
    end else begin
      e.pcEn = 1; e.ifidEn = 1; e.idexEn = 1; e.flush = 0;
    end
    expQ.push_back(e);

    if (!s.rst) begin
      busyFrom = 0;
      busyTo   = -1;
      doneAt   = -1;
    end else if (!e.busy && s.mdStart && !stall && !s.memWait) begin
      lat      = s.mdDiv ? DIV_L : MULT_L;
      busyFrom = cyc + 1;
      busyTo   = cyc + lat;
      doneAt   = cyc + lat + 1;
    end
`ifdef PC_STALL_PERF_EN
    if (!s.rst) begin
      expStallCnt  = 0;
      expFreezeCnt = 0;
    end else begin
      if (stall && !s.memWait) expStallCnt++;
      if (s.memWait) expFreezeCnt++;
    end
`endif
    cyc++;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput(e);
      end
    end
  end

  initial begin : stimulus
    stim_t s;
    rst_n = 1'b0;
    bus.RsD = '0; bus.RtD = '0; bus.UseRsD = 0; bus.UseRtD = 0; bus.IsJBrD = 0;
    bus.MdStartD = 0; bus.MdDivD = 0; bus.MdUseD = 0; bus.WriteRegE = '0;
    bus.RegWriteE = 0; bus.MemReadE = 0; bus.WriteRegM = '0; bus.MemReadM = 0;
    bus.MemWaitM = 0;

    s = quiet(); s.rst = 0;
    applyStimulus(s);
    applyStimulus(s);
    applyStimulus(quiet());

    // Load-use, then the load moves to MEM and the consumer proceeds.
    s = quiet(); s.memRdE = 1; s.regWrE = 1; s.wrE = 8; s.useRs = 1; s.rs = 8;
    applyStimulus(s);
    s = quiet(); s.memRdM = 1; s.wrM = 8; s.useRs = 1; s.rs = 8;
    applyStimulus(s);

    // Branch waits on EX ALU result, then on a load in MEM, then releases.
    s = quiet(); s.isJBr = 1; s.useRt = 1; s.rt = 9; s.regWrE = 1; s.wrE = 9;
    applyStimulus(s);
    s = quiet(); s.isJBr = 1; s.useRt = 1; s.rt = 9; s.memRdM = 1; s.wrM = 9;
    applyStimulus(s);
    s = quiet(); s.isJBr = 1; s.useRt = 1; s.rt = 9;
    applyStimulus(s);
    applyStimulus(quiet());

    // $0 never creates a load-use hazard.
    s = quiet(); s.useRs = 1; s.rs = 0; s.wrE = 0; s.memRdE = 1; s.regWrE = 1;
    applyStimulus(s);

    // Divide with an mflo waiting behind it and a freeze with load-use mid-way.
    s = quiet(); s.mdStart = 1; s.mdDiv = 1;
    applyStimulus(s);
    for (int i = 0; i < DIV_L + 2; i++) begin
      s = quiet(); s.mdUse = 1;
      if (i == 10) begin
        s.memWait = 1; s.memRdE = 1; s.wrE = 8; s.useRs = 1; s.rs = 8;
      end
      applyStimulus(s);
    end

    // Back-to-back mult: the second start waits and is taken on the done cycle.
    s = quiet(); s.mdStart = 1;
    applyStimulus(s);
    for (int i = 0; i < MULT_L + 1; i++) applyStimulus(s);
    for (int i = 0; i < MULT_L + 2; i++) applyStimulus(quiet());

    // Async reset with the divide counter at 10, then a fresh mult.
    s = quiet(); s.mdStart = 1; s.mdDiv = 1;
    applyStimulus(s);
    for (int i = 0; i < 22; i++) applyStimulus(quiet());
    s = quiet(); s.rst = 0;
    applyStimulus(s);
    applyStimulus(s);
    s = quiet(); s.mdStart = 1;
    applyStimulus(s);
    for (int i = 0; i < MULT_L + 2; i++) applyStimulus(quiet());

    // Random traffic over a small register pool to provoke frequent matches.
    for (int i = 0; i < 3000; i++) begin
      s.rst     = ($urandom_range(0, 299) != 0);
      s.rs      = 5'($urandom_range(0, 3));
      s.rt      = 5'($urandom_range(0, 3));
      s.useRs   = 1'($urandom);
      s.useRt   = 1'($urandom);
      s.isJBr   = ($urandom_range(0, 3) == 0);
      s.mdStart = ($urandom_range(0, 5) == 0);
      s.mdDiv   = ($urandom_range(0, 3) == 0);
      s.mdUse   = ($urandom_range(0, 4) == 0);
      s.wrE     = 5'($urandom_range(0, 3));
      s.regWrE  = 1'($urandom);
      s.memRdE  = ($urandom_range(0, 3) == 0);
      s.wrM     = 5'($urandom_range(0, 3));
      s.memRdM  = ($urandom_range(0, 3) == 0);
      s.memWait = ($urandom_range(0, 7) == 0);
      applyStimulus(s);
    end
    applyStimulus(quiet());

    @(posedge clk);
    #1;
    @(negedge clk);
    #1;
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL queueDrain: %0d entries left, expected 0", expQ.size());
    end
`ifdef PC_STALL_PERF_EN
    checks++;
    if (longint'(StallCnt) != expStallCnt) begin
      errors++;
      $display("[TB] FAIL StallCnt: got %0d, expected %0d", StallCnt, expStallCnt);
    end
    checks++;
    if (longint'(FreezeCnt) != expFreezeCnt) begin
      errors++;
      $display("[TB] FAIL FreezeCnt: got %0d, expected %0d", FreezeCnt, expFreezeCnt);
    end
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
